dfs_traversal: RTL

DFS_TRAVERSAL -- requirements
Module: dfs_traversal

---
 rtl/dfs_traversal.sv | 134 +++++++++++++
 1 files changed

// File: rtl/dfs_traversal.sv
// Pre-order depth-first walker over a node memory, using an external stack for
// pending children and streaming leaf addresses out on a valid/ready port.
module dfs_traversal #(
  parameter int NODE_ADDR_WIDTH = 8,
  parameter int CHILD_CNT_WIDTH = 2
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         start,
  input  logic [NODE_ADDR_WIDTH-1:0]                   root_addr,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         overflow,
  output logic [NODE_ADDR_WIDTH-1:0]                   mem_addr,
  input  logic [NODE_ADDR_WIDTH+CHILD_CNT_WIDTH:0]     mem_rdata,
  output logic                                         leaf_valid,
  input  logic                                         leaf_ready,
  output logic [NODE_ADDR_WIDTH-1:0]                   leaf_addr,
  output logic                                         stk_push,
  output logic                                         stk_pop,
  output logic [NODE_ADDR_WIDTH-1:0]                   stk_data_in,
  input  logic [NODE_ADDR_WIDTH-1:0]                   stk_data_out,
  input  logic                                         stk_just_popped,
  input  logic                                         stk_full,
  input  logic                                         stk_empty,
  output logic [3:0]                                   state_dbg
);

  localparam int AW = NODE_ADDR_WIDTH;
  localparam int CW = CHILD_CNT_WIDTH;
  localparam int MW = 1 + CW + AW;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_PUSH     = 4'd3;
  localparam logic [3:0] S_EMIT     = 4'd4;
  localparam logic [3:0] S_NEXT     = 4'd5;
  localparam logic [3:0] S_WAIT_POP = 4'd6;
  localparam logic [3:0] S_DRAIN    = 4'd7;
  localparam logic [3:0] S_DONE     = 4'd8;

  // Leaf handshake: a leaf transfers on a cycle where leaf_valid && leaf_ready;
  // leaf_addr is held stable while leaf_valid is high and leaf_ready is low.

  logic [3:0]    state;
  logic [AW-1:0] cur;
  logic [AW-1:0] first_child;
  logic [CW-1:0] cnt;

  logic          rd_is_leaf;
  logic [CW-1:0] rd_num_children;
  logic [AW-1:0] rd_first_child;

  assign rd_is_leaf      = mem_rdata[MW-1];
  assign rd_num_children = mem_rdata[AW +: CW];
  assign rd_first_child  = mem_rdata[AW-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cur         <= '0;
      first_child <= '0;
      cnt         <= '0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur      <= root_addr;
            overflow <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          if (rd_is_leaf) begin
            state <= S_EMIT;
          end else if (rd_num_children == '0) begin
            state <= S_NEXT;
          end else begin
            first_child <= rd_first_child;
            cnt         <= rd_num_children;
            state       <= S_PUSH;
          end
        end
        S_PUSH: begin
          if (stk_full) begin
            overflow <= 1'b1;
            state    <= S_DRAIN;
          end else begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) state <= S_NEXT;
          end
        end
        S_EMIT: begin
          if (leaf_ready) state <= S_NEXT;
        end
        S_NEXT: begin
          if (stk_empty) state <= S_DONE;
          else           state <= S_WAIT_POP;
        end
        S_WAIT_POP: begin
          // A missing pop acknowledge is a stack protocol fault; abort and flag it.
          if (stk_just_popped) begin
            cur   <= stk_data_out;
            state <= S_FETCH;
          end else begin
            overflow <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DRAIN: begin
          if (stk_empty) state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Children are pushed highest index first so the lowest index pops first.
  assign stk_data_in = first_child + AW'(cnt) - AW'(1);
  assign stk_push    = (state == S_PUSH) && !stk_full;
  assign stk_pop     = ((state == S_NEXT) || (state == S_DRAIN)) && !stk_empty;

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign mem_addr   = cur;
  assign leaf_valid = (state == S_EMIT);
  assign leaf_addr  = cur;
  assign state_dbg  = state;

endmodule
